// File: rtl/shift_sequencer_pkg.sv
// shift_pkg: shared definitions for the shift sequencer.
//   DATA_W  - operand width
//   op_t    - operation encodings (OP_SHL/OP_SHR/OP_ROL/OP_ROR)
//   state_t - controller FSM states
//   req_t   - latched request (op + working data)
package shift_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    OP_SHL = 2'b00,  // zero fill from bit0
    OP_SHR = 2'b01,  // logical, zero fill from bit15
    OP_ROL = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    op_t               op;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request/result handshake bundle.
//   in_valid/in_ready/in_op/in_amt/in_data - request channel
//   out_valid/out_ready/out_data           - result channel
//   master: request producer / result consumer; slave: the sequencer
interface shift_sequencer_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_op;
  logic [3:0]   in_amt;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport master (
    output in_valid, in_op, in_amt, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_op, in_amt, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/shift_sequencer_step.sv
// shift_step: one 1-bit step of a shift/rotate, purely combinational.
//   i_op   - operation select
//   i_data - operand
//   o_data - operand after one step
module shift_step
  import shift_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  op_t          i_op,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_op)
      OP_SHL:  o_data = {i_data[W-2:0], 1'b0};
      OP_SHR:  o_data = {1'b0, i_data[W-1:1]};
      OP_ROL:  o_data = {i_data[W-2:0], i_data[W-1]};
      OP_ROR:  o_data = {i_data[0], i_data[W-1:1]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter/rotator, one bit per clock.
//   clk   - clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - request/result handshake (slave side)
//   busy  - high whenever the FSM is not idle
// An accepted request of amount N produces its result N edges later and
// holds it until the consumer takes it.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  shift_sequencer_if.slave    bus,
  output logic                busy
);

  state_t       r_state, w_state_nxt;
  logic [3:0]   r_cnt,   w_cnt_nxt;
  req_t         r_req,   w_req_nxt;
  logic [W-1:0] w_step;
  logic         w_accept;

  shift_step #(.W(W)) u_step (
    .i_op   (r_req.op),
    .i_data (r_req.data),
    .o_data (w_step)
  );

  // in_ready is gated by rst_n so it reads low during reset regardless of state.
  assign bus.in_ready  = rst_n & (r_state == ST_IDLE);
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (r_state == ST_DONE);
  // Result comes straight from the data register; no path from in_*.
  assign bus.out_data  = r_req.data;
  assign busy          = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_req_nxt.op   = op_t'(bus.in_op);
          w_req_nxt.data = bus.in_data;
          w_cnt_nxt      = bus.in_amt;
          w_state_nxt    = (bus.in_amt == 4'd0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_req_nxt.data = w_step;
        w_cnt_nxt      = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter: W, 16, data width (fixed at 16 for this release; other values unsupported).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  block can accept request.
REQ-006 in_op  input  2  operation: 00 SHL (zero fill), 01 SHR logical (zero fill), 10 ROL, 11 ROR.
REQ-007 in_amt  input  4  shift/rotate amount, 0..15.
REQ-008 in_data  input  16  operand.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out_data  output  16  result.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE, and SHALL be 0 while rst_n is low.
REQ-015 Accept SHALL occur on an edge with in_valid and in_ready both high; op, amt and data are latched into internal registers on that edge.
REQ-016 On accept with amt=0, next state SHALL be DONE with the data register unchanged.
REQ-017 On accept with amt>0, next state SHALL be SHIFT with the count register set to amt.
REQ-018 Each SHIFT edge SHALL apply exactly one 1-bit step of the latched op to the data register and decrement the count register.
REQ-019 SHIFT SHALL go to DONE on the edge where count decrements from 1 to 0.
REQ-020 out_valid SHALL rise exactly N edges after the accepting edge, where N=amt; for N=0 it is visible in the cycle immediately after accept.
REQ-021 Step definitions: SHL shifts bit k to k+1 and bit0 becomes 0; SHR shifts bit k to k-1 and bit15 becomes 0; ROL moves bit15 to bit0; ROR moves bit0 to bit15.
REQ-022 In DONE, out_valid SHALL be 1 and out_data SHALL equal the data register, held stable until out_ready.
REQ-023 An edge in DONE with out_ready=1 SHALL return the FSM to IDLE and drop out_valid.
REQ-024 in_valid outside IDLE SHALL be ignored, with no latch and no side effect.
REQ-025 out_data SHALL be registered; no combinational path from in_* to out_*.
REQ-026 Latched op and amt SHALL be unaffected by in_* changes after accept.

Reset
REQ-027 An edge with rst_n=0 SHALL force IDLE, out_valid=0, out_data=16'h0000, count=0 and busy=0, from any state including mid-SHIFT.
REQ-028 An in-flight operation aborted by reset SHALL produce no output.
REQ-029 in_ready SHALL be 1 on the first cycle after rst_n returns high.

Structure
REQ-030 Shared package shift_pkg SHALL hold the op encodings (OP_SHL, OP_SHR, OP_ROL, OP_ROR) and the FSM state typedef/constants.
REQ-031 The 1-bit step SHALL be a combinational sub-module, shift_step (op, data in, data out), instantiated once.
REQ-032 The controller SHALL contain only the FSM, the 4-bit count register, and the op/data registers.

Verification
REQ-033 Scenario: SHL, amt=4, data=16'h8421 -> out_data=16'h4210 with out_valid rising 4 edges after accept.
REQ-034 Scenario: ROR, amt=1, data=16'h0001 -> 16'h8000 after 1 edge; then SHR, amt=12, data=16'hF000 -> 16'h000F after 12 edges.
REQ-035 Scenario: ROL, amt=15, data=16'h8001 -> 16'hC000 after 15 edges; busy high throughout.
REQ-036 Scenario: SHR, amt=0, data=16'hBEEF -> 16'hBEEF with out_valid in the cycle after accept; in_ready is 0 until the handshake.
REQ-037 Scenario: out_ready held low 5 cycles in DONE, with a new in_valid driven -> out_data stable, in_ready=0, request not latched; IDLE one edge after out_ready=1.
REQ-038 Scenario: rst_n low for one edge on the 3rd SHIFT cycle of amt=10 -> out_valid=0, out_data=0, busy=0, no result emitted, in_ready=1 after release.
